// File: rtl/titan_if_prefetch_if.sv
// Instruction-memory request bus plus ID-stage valid/stall handshake of the Titan fetch front end.
// master = prefetch unit, slave = memory / ID-stage side.
interface titan_if_prefetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        imem_err_i;
    logic        id_stall;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instruction_o;
    logic        id_inst_addr_misaligned_o;
    logic        id_inst_access_fault_o;

    modport master (
        output imem_req_o, imem_addr_o,
        output id_valid_o, id_pc_o, id_instruction_o,
        output id_inst_addr_misaligned_o, id_inst_access_fault_o,
        input  imem_ack_i, imem_data_i, imem_err_i, id_stall
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        input  id_valid_o, id_pc_o, id_instruction_o,
        input  id_inst_addr_misaligned_o, id_inst_access_fault_o,
        output imem_ack_i, imem_data_i, imem_err_i, id_stall
    );
endinterface

// File: rtl/titan_if_prefetch.sv
// Titan instruction-fetch front end: PC generator, single-outstanding imem port, DEPTH-entry prefetch queue.
// Optional performance counters are built only when TITAN_IF_PERF_EN is defined.
module titan_if_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       if_stall,
    input  logic [1:0]                 if_pc_sel_i,
    input  logic [31:0]                pc_branch_address_i,
    input  logic [31:0]                pc_jump_address_i,
    input  logic [31:0]                exception_pc_i,
    output logic [31:0]                if_pc_o,
    output logic [31:0]                perf_fetch_cnt_o,
    output logic [31:0]                perf_drop_cnt_o,
    titan_if_prefetch_if.master        bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP, ST_HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
        logic        flt;
    } entry_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic          req_reg, req_next;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          redirect, pop, push;
    logic [31:0]   target, pc_plus4;
    entry_t        push_entry, head;
    entry_t        q_entry [DEPTH];

    assign redirect = (if_pc_sel_i != 2'd0);
    assign pop      = (count_reg != '0) && !bus.id_stall;
    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        case (if_pc_sel_i)
            2'd1:    target = pc_branch_address_i;
            2'd2:    target = pc_jump_address_i;
            default: target = exception_pc_i;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        req_next   = req_reg;
        push       = 1'b0;
        push_entry = '{pc: pc_reg, inst: NOP_INST, mis: 1'b0, flt: 1'b0};
        if (redirect) begin
            pc_next = target;
            if (req_reg && !bus.imem_ack_i) begin
                // Request still in flight: keep it up until memory answers, then throw the answer away.
                state_next = ST_DROP;
            end else if (!if_stall && target[1:0] == 2'b00) begin
                // Queue is empty after the flush, so the target can be requested on the very next cycle.
                req_next   = 1'b1;
                addr_next  = target;
                state_next = ST_WAIT;
            end else begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!if_stall && count_reg < CW'(DEPTH)) begin
                        if (pc_reg[1:0] != 2'b00) begin
                            push           = 1'b1;
                            push_entry.mis = 1'b1;
                            state_next     = ST_HALT;
                        end else begin
                            req_next   = 1'b1;
                            addr_next  = pc_reg;
                            state_next = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ack_i) begin
                        push       = 1'b1;
                        push_entry = '{pc: addr_reg, inst: bus.imem_data_i, mis: 1'b0, flt: bus.imem_err_i};
                        if (bus.imem_err_i) begin
                            req_next   = 1'b0;
                            state_next = ST_HALT;
                        end else begin
                            pc_next = pc_plus4;
                            if (!if_stall && (pop || count_reg < CW'(DEPTH - 1)) && pc_plus4[1:0] == 2'b00) begin
                                addr_next = pc_plus4;
                            end else begin
                                req_next   = 1'b0;
                                state_next = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack_i) begin
                        req_next   = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_ADDR;
            addr_reg   <= RESET_ADDR;
            req_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            req_reg   <= req_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t entry_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    entry_reg <= '0;
                end else if (push && wr_ptr_reg == AW'(gi)) begin
                    entry_reg <= push_entry;
                end
            end
            assign q_entry[gi] = entry_reg;
        end
    endgenerate

    // Stale slots are masked so an empty queue always presents zeros to ID.
    assign head                          = q_entry[rd_ptr_reg];
    assign bus.id_valid_o                = (count_reg != '0);
    assign bus.id_pc_o                   = bus.id_valid_o ? head.pc   : 32'd0;
    assign bus.id_instruction_o          = bus.id_valid_o ? head.inst : 32'd0;
    assign bus.id_inst_addr_misaligned_o = bus.id_valid_o && head.mis;
    assign bus.id_inst_access_fault_o    = bus.id_valid_o && head.flt;
    assign bus.imem_req_o                = req_reg;
    assign bus.imem_addr_o               = addr_reg;
    assign if_pc_o                       = pc_reg;

`ifdef TITAN_IF_PERF_EN
    logic [31:0] fetch_cnt_reg, drop_cnt_reg;
    logic        discard;

    // A response is thrown away when it lands during a redirect or while draining in DROP.
    assign discard = req_reg && bus.imem_ack_i && (redirect || state_reg == ST_DROP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (push) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            drop_cnt_reg <= drop_cnt_reg + (redirect ? 32'(count_reg) : 32'd0) + 32'(discard);
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_reg;
    assign perf_drop_cnt_o  = drop_cnt_reg;
`else
    assign perf_fetch_cnt_o = 32'd0;
    assign perf_drop_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_titan_if_prefetch.sv
// Self-checking bench for titan_if_prefetch: directed scenarios plus a randomized run scored against
// an address-stream model (ID must see target, target+4, ... up to the first faulting entry).
module tb_titan_if_prefetch;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
`ifdef TITAN_IF_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] br = 32'd0, jmp = 32'd0, exc = 32'd0;
    logic [31:0] if_pc, perf_fetch, perf_drop;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    titan_if_prefetch_if bus ();

    titan_if_prefetch #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
        .clk_i(clk), .rst_i(rst), .if_stall(if_stall), .if_pc_sel_i(sel),
        .pc_branch_address_i(br), .pc_jump_address_i(jmp), .exception_pc_i(exc),
        .if_pc_o(if_pc), .perf_fetch_cnt_o(perf_fetch), .perf_drop_cnt_o(perf_drop), .bus(bus)
    );

    // Memory model: word = addr ^ data_key, per-request latency in [lat_min, lat_max].
    int          wait_cnt = 0, cur_lat = 0, lat_min = 0, lat_max = 0;
    logic [31:0] data_key = 32'd0, err_addr = 32'd0;
    bit          err_addr_en = 1'b0, err_rand_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ data_key;
    endfunction
    function automatic bit mem_err(input logic [31:0] a);
        return (err_addr_en && a == err_addr) || (err_rand_en && a[6:2] == 5'h13);
    endfunction

    assign bus.imem_ack_i  = bus.imem_req_o && (wait_cnt == cur_lat);
    assign bus.imem_data_i = bus.imem_addr_o ^ data_key;
    assign bus.imem_err_i  = bus.imem_ack_i &&
                             ((err_addr_en && bus.imem_addr_o == err_addr) ||
                              (err_rand_en && bus.imem_addr_o[6:2] == 5'h13));

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
            cur_lat  <= lat_min;
        end else if (bus.imem_ack_i) begin
            wait_cnt <= 0;
            cur_lat  <= int'($urandom_range(lat_max, lat_min));
        end else if (bus.imem_req_o) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; sel = 2'd0; if_stall = 1'b0; bus.id_stall = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lat_min = 0; lat_max = 0; data_key = 32'd0;
        bus.id_stall = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
        n_cmp++; if (bus.imem_addr_o !== RESET_ADDR) begin n_err++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr_o, RESET_ADDR); end
        n_cmp++; if (if_pc !== RESET_ADDR) begin n_err++; $display("FAIL reset_pc: got %h want %h", if_pc, RESET_ADDR); end
        n_cmp++; if (bus.id_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.id_valid_o); end
        n_cmp++; if ({bus.id_pc_o, bus.id_instruction_o} !== 64'd0) begin n_err++; $display("FAIL reset_id: got %h/%h want 0/0", bus.id_pc_o, bus.id_instruction_o); end
        n_cmp++; if ({bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o); end
        n_cmp++; if ({perf_fetch, perf_drop} !== 64'd0) begin n_err++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch, perf_drop); end
        $display("reset: mid-stream reset applied, state inspected");
    endtask

    task automatic test_stream();
        int first_req = -1, first_val = -1, got = 0;
        logic [31:0] exp_pc = RESET_ADDR;
        lat_min = 0; lat_max = 0; data_key = 32'd0;
        do_reset();
        for (int n = 0; n < 14; n++) begin
            if (bus.imem_req_o && first_req < 0) first_req = n;
            if (bus.id_valid_o) begin
                if (first_val < 0) first_val = n;
                n_cmp++;
                if ({bus.id_pc_o, bus.id_instruction_o} !== {exp_pc, exp_pc}) begin
                    n_err++; $display("FAIL stream_entry: got pc=%h inst=%h want %h/%h", bus.id_pc_o, bus.id_instruction_o, exp_pc, exp_pc);
                end
                $display("stream: id pc=%h inst=%h", bus.id_pc_o, bus.id_instruction_o);
                exp_pc += 32'd4; got++;
            end
            @(negedge clk);
        end
        n_cmp++; if (first_req != 1) begin n_err++; $display("FAIL stream_first_req: got cycle %0d want 1", first_req); end
        n_cmp++; if (first_val != 2) begin n_err++; $display("FAIL stream_first_valid: got cycle %0d want 2", first_val); end
        n_cmp++; if (got != 12) begin n_err++; $display("FAIL stream_rate: got %0d entries want 12", got); end
    endtask

    task automatic test_id_stall();
        int got = 0;
        logic [31:0] exp_pc = RESET_ADDR;
        lat_min = 0; lat_max = 0; data_key = 32'd0;
        do_reset();
        bus.id_stall = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", bus.imem_req_o); end
        n_cmp++; if ({bus.id_valid_o, bus.id_pc_o} !== {1'b1, RESET_ADDR}) begin n_err++; $display("FAIL stall_head: got v=%b pc=%h want 1/%h", bus.id_valid_o, bus.id_pc_o, RESET_ADDR); end
        n_cmp++; if (perf_fetch !== (PERF_ON ? 32'd4 : 32'd0)) begin n_err++; $display("FAIL stall_fetch_cnt: got %0d want %0d", perf_fetch, PERF_ON ? 4 : 0); end
        bus.id_stall = 1'b0;
        for (int n = 0; n < 30 && got < 5; n++) begin
            if (bus.id_valid_o) begin
                n_cmp++;
                if (bus.id_pc_o !== exp_pc) begin n_err++; $display("FAIL stall_order: got pc=%h want %h", bus.id_pc_o, exp_pc); end
                $display("stall: id pc=%h", bus.id_pc_o);
                exp_pc += 32'd4; got++;
            end
            @(negedge clk);
        end
        n_cmp++; if (got != 5) begin n_err++; $display("FAIL stall_drain: got %0d entries want 5", got); end
    endtask

    task automatic test_jump_drop();
        bit found = 1'b0, done = 1'b0;
        int viol = 0;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        lat_min = 3; lat_max = 3; data_key = 32'h5A5A_0000;
        do_reset();
        bus.id_stall = 1'b1;
        for (int n = 0; n < 60 && !found; n++) begin
            if (bus.imem_req_o && bus.imem_addr_o == 32'h8) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL jump_setup: request to 0x8 not seen"); end
        if (found) begin
            jmp = 32'h100; sel = 2'd2;
            @(negedge clk);
            sel = 2'd0; bus.id_stall = 1'b0;
            n_cmp++; if ({bus.id_valid_o, if_pc} !== {1'b0, 32'h100}) begin n_err++; $display("FAIL jump_flush: got v=%b pc=%h want 0/100", bus.id_valid_o, if_pc); end
            n_cmp++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL jump_hold: got req=%b addr=%h want 1/8", bus.imem_req_o, bus.imem_addr_o); end
            prev_req = bus.imem_req_o; prev_ack = bus.imem_ack_i; prev_addr = bus.imem_addr_o;
            for (int n = 0; n < 40 && !done; n++) begin
                @(negedge clk);
                if (prev_req && !prev_ack && (!bus.imem_req_o || bus.imem_addr_o != prev_addr)) viol++;
                prev_req = bus.imem_req_o; prev_ack = bus.imem_ack_i; prev_addr = bus.imem_addr_o;
                if (bus.id_valid_o) begin
                    done = 1'b1;
                    n_cmp++;
                    if ({bus.id_pc_o, bus.id_instruction_o} !== {32'h100, mem_word(32'h100)}) begin
                        n_err++; $display("FAIL jump_entry: got pc=%h inst=%h want 100/%h", bus.id_pc_o, bus.id_instruction_o, mem_word(32'h100));
                    end
                    n_cmp++;
                    if ({perf_fetch, perf_drop} !== (PERF_ON ? {32'd3, 32'd3} : 64'd0)) begin
                        n_err++; $display("FAIL jump_perf: got fetch=%0d drop=%0d want %0d/%0d", perf_fetch, perf_drop, PERF_ON ? 3 : 0, PERF_ON ? 3 : 0);
                    end
                    $display("jump: id pc=%h inst=%h", bus.id_pc_o, bus.id_instruction_o);
                end
            end
            n_cmp++; if (!done) begin n_err++; $display("FAIL jump_timeout: no entry within 40 cycles"); end
            n_cmp++; if (viol != 0) begin n_err++; $display("FAIL jump_addr_stable: got %0d violations want 0", viol); end
        end
    endtask

    task automatic test_misaligned();
        int req_hi = 0, entries = 0;
        bit done = 1'b0;
        lat_min = 0; lat_max = 0; data_key = 32'h0F0F_0000;
        do_reset();
        repeat (4) @(negedge clk);
        br = 32'h102; sel = 2'd1;
        @(negedge clk);
        sel = 2'd0;
        n_cmp++; if ({bus.id_valid_o, if_pc} !== {1'b0, 32'h102}) begin n_err++; $display("FAIL mis_flush: got v=%b pc=%h want 0/102", bus.id_valid_o, if_pc); end
        for (int n = 0; n < 12; n++) begin
            if (bus.imem_req_o) req_hi++;
            if (bus.id_valid_o) begin
                entries++;
                if (entries == 1) begin
                    n_cmp++;
                    if ({bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o} !== {32'h102, NOP_INST, 1'b1, 1'b0}) begin
                        n_err++; $display("FAIL mis_entry: got pc=%h inst=%h mis=%b flt=%b want 102/%h/1/0", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o, NOP_INST);
                    end
                end
                $display("mis: id pc=%h inst=%h mis=%b", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o);
            end
            @(negedge clk);
        end
        n_cmp++; if (req_hi != 0) begin n_err++; $display("FAIL mis_no_req: got %0d request cycles want 0", req_hi); end
        n_cmp++; if (entries != 1) begin n_err++; $display("FAIL mis_halt: got %0d entries want 1", entries); end
        exc = 32'h200; sel = 2'd3;
        @(negedge clk);
        sel = 2'd0;
        n_cmp++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL exc_req: got req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o); end
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (bus.id_valid_o) begin
                done = 1'b1;
                n_cmp++;
                if ({bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o} !== {32'h200, mem_word(32'h200), 1'b0}) begin
                    n_err++; $display("FAIL exc_entry: got pc=%h inst=%h mis=%b want 200/%h/0", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, mem_word(32'h200));
                end
                $display("exc: id pc=%h inst=%h", bus.id_pc_o, bus.id_instruction_o);
            end
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL exc_timeout: no entry within 10 cycles"); end
    endtask

    task automatic test_bus_error();
        bit seen = 1'b0, done = 1'b0;
        int req_hi = 0, val_hi = 0;
        logic [31:0] exp_pc = RESET_ADDR;
        lat_min = 1; lat_max = 1; data_key = 32'h3C3C_0000;
        err_addr = 32'h40; err_addr_en = 1'b1;
        do_reset();
        for (int n = 0; n < 80 && !seen; n++) begin
            if (bus.id_valid_o) begin
                n_cmp++;
                if ({bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o} !== {exp_pc, mem_word(exp_pc), 1'b0, exp_pc == 32'h40}) begin
                    n_err++; $display("FAIL err_entry: got pc=%h inst=%h mis=%b flt=%b want %h/%h/0/%b", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o, exp_pc, mem_word(exp_pc), exp_pc == 32'h40);
                end
                $display("err: id pc=%h inst=%h flt=%b", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_access_fault_o);
                if (bus.id_inst_access_fault_o) seen = 1'b1;
                exp_pc += 32'd4;
            end
            @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL err_seen: fault entry never reached ID"); end
        for (int n = 0; n < 10; n++) begin
            if (bus.imem_req_o) req_hi++;
            if (bus.id_valid_o) val_hi++;
            @(negedge clk);
        end
        n_cmp++; if ({req_hi, val_hi} != {32'd0, 32'd0}) begin n_err++; $display("FAIL err_halt: got %0d req / %0d valid cycles want 0/0", req_hi, val_hi); end
        err_addr_en = 1'b0;
        jmp = 32'h300; sel = 2'd2;
        @(negedge clk);
        sel = 2'd0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (bus.id_valid_o) begin
                done = 1'b1;
                n_cmp++;
                if ({bus.id_pc_o, bus.id_instruction_o, bus.id_inst_access_fault_o} !== {32'h300, mem_word(32'h300), 1'b0}) begin
                    n_err++; $display("FAIL err_resume: got pc=%h inst=%h flt=%b want 300/%h/0", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_access_fault_o, mem_word(32'h300));
                end
                $display("err: resumed pc=%h", bus.id_pc_o);
            end
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL err_resume_timeout: no entry within 10 cycles"); end
    endtask

    task automatic test_redirect_ack_pop();
        lat_min = 0; lat_max = 0; data_key = 32'h1234_0000;
        do_reset();
        repeat (5) @(negedge clk);
        n_cmp++; if ({bus.imem_req_o, bus.imem_ack_i, bus.id_valid_o} !== 3'b111) begin n_err++; $display("FAIL rap_setup: got req/ack/valid=%b%b%b want 111", bus.imem_req_o, bus.imem_ack_i, bus.id_valid_o); end
        jmp = 32'h400; sel = 2'd2;
        @(negedge clk);
        sel = 2'd0;
        n_cmp++; if (bus.id_valid_o !== 1'b0) begin n_err++; $display("FAIL rap_empty: got valid=%b want 0", bus.id_valid_o); end
        n_cmp++; if ({bus.imem_req_o, bus.imem_addr_o, if_pc} !== {1'b1, 32'h400, 32'h400}) begin n_err++; $display("FAIL rap_req: got req=%b addr=%h pc=%h want 1/400/400", bus.imem_req_o, bus.imem_addr_o, if_pc); end
        n_cmp++; if (perf_drop !== (PERF_ON ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL rap_drop_cnt: got %0d want %0d", perf_drop, PERF_ON ? 2 : 0); end
        @(negedge clk);
        n_cmp++; if ({bus.id_valid_o, bus.id_pc_o, bus.id_instruction_o} !== {1'b1, 32'h400, mem_word(32'h400)}) begin
            n_err++; $display("FAIL rap_entry: got v=%b pc=%h inst=%h want 1/400/%h", bus.id_valid_o, bus.id_pc_o, bus.id_instruction_o, mem_word(32'h400));
        end
        $display("rap: id pc=%h inst=%h", bus.id_pc_o, bus.id_instruction_o);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = RESET_ADDR, target, exp_inst;
        logic        prev_req = 1'b0, prev_ack = 1'b0, exp_mis, exp_flt, new_stall;
        logic [31:0] prev_addr = 32'd0;
        logic [1:0]  new_sel;
        bit          dead = 1'b0;
        int          pops = 0;
        lat_min = 0; lat_max = 3; data_key = $urandom; err_rand_en = 1'b1;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (prev_req && !prev_ack) begin
                n_cmp++;
                if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, prev_addr}) begin
                    n_err++; $display("FAIL rnd_addr_stable: got req=%b addr=%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, prev_addr);
                end
            end
            if (dead) begin
                n_cmp++;
                if ({bus.id_valid_o, bus.imem_req_o} !== 2'b00) begin
                    n_err++; $display("FAIL rnd_halt: got valid=%b req=%b want 0/0", bus.id_valid_o, bus.imem_req_o);
                end
            end
            new_stall = ($urandom_range(3) == 0);
            new_sel   = ($urandom_range(24) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
            if (bus.id_valid_o && !new_stall && new_sel == 2'd0) begin
                exp_mis  = (exp_pc[1:0] != 2'b00);
                exp_inst = exp_mis ? NOP_INST : mem_word(exp_pc);
                exp_flt  = !exp_mis && mem_err(exp_pc);
                n_cmp++;
                if ({bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o} !== {exp_pc, exp_inst, exp_mis, exp_flt}) begin
                    n_err++; $display("FAIL rnd_entry: got pc=%h inst=%h mis=%b flt=%b want %h/%h/%b/%b", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o, exp_pc, exp_inst, exp_mis, exp_flt);
                end
                $display("rnd: id pc=%h inst=%h mis=%b flt=%b", bus.id_pc_o, bus.id_instruction_o, bus.id_inst_addr_misaligned_o, bus.id_inst_access_fault_o);
                if (exp_mis || exp_flt) dead = 1'b1;
                exp_pc += 32'd4;
                pops++;
            end
            if (new_sel != 2'd0) begin
                target = 32'($urandom_range(1023)) << 2;
                if ($urandom_range(7) == 0) target = target | 32'($urandom_range(3, 1));
                case (new_sel)
                    2'd1:    br  = target;
                    2'd2:    jmp = target;
                    default: exc = target;
                endcase
                exp_pc = target;
                dead   = 1'b0;
                $display("rnd: redirect sel=%0d target=%h", new_sel, target);
            end
            prev_req = bus.imem_req_o; prev_ack = bus.imem_ack_i; prev_addr = bus.imem_addr_o;
            bus.id_stall = new_stall;
            sel          = new_sel;
            if_stall     = ($urandom_range(4) == 0);
            @(negedge clk);
        end
        sel = 2'd0; if_stall = 1'b0; bus.id_stall = 1'b0; err_rand_en = 1'b0;
        n_cmp++; if (pops < 200) begin n_err++; $display("FAIL rnd_progress: got %0d entries want at least 200", pops); end
    endtask

    initial begin
        bus.id_stall = 1'b0;
        test_reset();
        test_stream();
        test_id_stall();
        test_jump_drop();
        test_misaligned();
        test_bus_error();
        test_redirect_ack_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
